// File: rtl/iir_pkg.sv
// Shared types and constants for the biquad IIR filters.
// Coefficients are signed fixed point; one is 1 << fractional bits.
package iir_pkg;

    typedef enum logic [2:0] {
        B0 = 3'd0,
        B1 = 3'd1,
        B2 = 3'd2,
        A1 = 3'd3,
        A2 = 3'd4
    } coeff_sel_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        BYP  = 2'd2
    } state_e;

    localparam int unsigned COEFF_FRAC_DEFAULT = 18;
    localparam int unsigned COEFF_ONE          = 1 << COEFF_FRAC_DEFAULT;

    function automatic logic [31:0] coeff_one(input int unsigned frac);
        return 32'd1 << frac;
    endfunction

endpackage

// File: rtl/iir_round_sat.sv
// Round-half-up and saturate a wide accumulator down to an output sample.
// ACC_FRAC - OUT_FRAC must be at least 1.
module iir_round_sat #(
    parameter int unsigned ACC_WIDTH = 39,
    parameter int unsigned ACC_FRAC  = 33,
    parameter int unsigned OUT_WIDTH = 16,
    parameter int unsigned OUT_FRAC  = 15
) (
    input  logic signed [ACC_WIDTH-1:0] acc,
    output logic signed [OUT_WIDTH-1:0] data_out,
    output logic                        ovf,
    output logic                        unf
);

    localparam int unsigned SHIFT = ACC_FRAC - OUT_FRAC;
    localparam logic signed [ACC_WIDTH-1:0] HALF  = ACC_WIDTH'(1) << (SHIFT - 1);
    localparam logic signed [ACC_WIDTH-1:0] MAX_V =
        {{(ACC_WIDTH - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] MIN_V =
        {{(ACC_WIDTH - OUT_WIDTH + 1){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

    logic signed [ACC_WIDTH-1:0] sum;
    logic signed [ACC_WIDTH-1:0] shifted;

    always_comb begin
        sum     = acc + HALF;
        shifted = sum >>> SHIFT;
        ovf     = shifted > MAX_V;
        unf     = shifted < MIN_V;
        if (ovf) begin
            data_out = MAX_V[OUT_WIDTH-1:0];
        end else if (unf) begin
            data_out = MIN_V[OUT_WIDTH-1:0];
        end else begin
            data_out = shifted[OUT_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/iir_biquad_cascade.sv
// Cascade of direct-form-I biquads sharing one 5-multiplier datapath,
// one section per clock, with runtime coefficients, bypass and flush.
module iir_biquad_cascade
    import iir_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned DATA_FRAC    = 15,
    parameter int unsigned COEFF_WIDTH  = 20,
    parameter int unsigned COEFF_FRAC   = 18,
    parameter int unsigned NUM_SECTIONS = 3,
    localparam int unsigned SEC_W     = (NUM_SECTIONS > 1) ? $clog2(NUM_SECTIONS) : 1,
    localparam int unsigned ACC_WIDTH = DATA_WIDTH + COEFF_WIDTH + 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic                   bypass,
    input  logic                   flush,
    input  logic                   coeff_wr_en,
    input  logic [SEC_W-1:0]       coeff_sec,
    input  logic [2:0]             coeff_sel,
    input  logic [COEFF_WIDTH-1:0] coeff_data,
    output logic                   coeff_wr_err,
    output logic                   out_valid,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   overflow,
    output logic                   underflow
);

    localparam logic signed [COEFF_WIDTH-1:0] ONE = COEFF_WIDTH'(coeff_one(COEFF_FRAC));

    state_e state_q, state_d;

    logic [SEC_W-1:0]             sec_idx_q;
    logic signed [DATA_WIDTH-1:0] cur_q;
    logic                         ovf_sticky_q, unf_sticky_q;

    logic signed [COEFF_WIDTH-1:0] b0_q [NUM_SECTIONS];
    logic signed [COEFF_WIDTH-1:0] b1_q [NUM_SECTIONS];
    logic signed [COEFF_WIDTH-1:0] b2_q [NUM_SECTIONS];
    logic signed [COEFF_WIDTH-1:0] a1_q [NUM_SECTIONS];
    logic signed [COEFF_WIDTH-1:0] a2_q [NUM_SECTIONS];

    logic signed [DATA_WIDTH-1:0] x1_q [NUM_SECTIONS];
    logic signed [DATA_WIDTH-1:0] x2_q [NUM_SECTIONS];
    logic signed [DATA_WIDTH-1:0] y1_q [NUM_SECTIONS];
    logic signed [DATA_WIDTH-1:0] y2_q [NUM_SECTIONS];

    logic                  out_valid_q, overflow_q, underflow_q, coeff_wr_err_q;
    logic [DATA_WIDTH-1:0] out_data_q;

    logic                         accept, last_sec, wr_ok;
    logic signed [ACC_WIDTH-1:0]  acc;
    logic signed [DATA_WIDTH-1:0] rounded;
    logic                         sat_ovf, sat_unf;

    function automatic logic signed [ACC_WIDTH-1:0] mul(
        input logic signed [COEFF_WIDTH-1:0] c,
        input logic signed [DATA_WIDTH-1:0]  d
    );
        return ACC_WIDTH'(c) * ACC_WIDTH'(d);
    endfunction

    assign accept   = in_valid && in_ready;
    assign last_sec = (32'(sec_idx_q) == NUM_SECTIONS - 1);
    assign wr_ok    = coeff_wr_en && (state_q == IDLE) && !accept &&
                      (coeff_sel <= 3'd4) && (32'(coeff_sec) < NUM_SECTIONS);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush overrides everything
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = bypass ? BYP : RUN;
            RUN:     if (last_sec) state_d = IDLE;
            BYP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    // FSM outputs
    always_comb begin
        in_ready = (state_q == IDLE) && !flush;
    end

    always_comb begin
        acc = mul(b0_q[sec_idx_q], cur_q)
            + mul(b1_q[sec_idx_q], x1_q[sec_idx_q])
            + mul(b2_q[sec_idx_q], x2_q[sec_idx_q])
            - mul(a1_q[sec_idx_q], y1_q[sec_idx_q])
            - mul(a2_q[sec_idx_q], y2_q[sec_idx_q]);
    end

    iir_round_sat #(
        .ACC_WIDTH (ACC_WIDTH),
        .ACC_FRAC  (COEFF_FRAC + DATA_FRAC),
        .OUT_WIDTH (DATA_WIDTH),
        .OUT_FRAC  (DATA_FRAC)
    ) u_round_sat (
        .acc      (acc),
        .data_out (rounded),
        .ovf      (sat_ovf),
        .unf      (sat_unf)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sec_idx_q      <= '0;
            cur_q          <= '0;
            ovf_sticky_q   <= 1'b0;
            unf_sticky_q   <= 1'b0;
            out_valid_q    <= 1'b0;
            out_data_q     <= '0;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
            coeff_wr_err_q <= 1'b0;
            for (int s = 0; s < int'(NUM_SECTIONS); s++) begin
                b0_q[s] <= ONE;
                b1_q[s] <= '0;
                b2_q[s] <= '0;
                a1_q[s] <= '0;
                a2_q[s] <= '0;
                x1_q[s] <= '0;
                x2_q[s] <= '0;
                y1_q[s] <= '0;
                y2_q[s] <= '0;
            end
        end else begin
            out_valid_q    <= 1'b0;
            coeff_wr_err_q <= coeff_wr_en && !wr_ok;
            if (flush) begin
                for (int s = 0; s < int'(NUM_SECTIONS); s++) begin
                    x1_q[s] <= '0;
                    x2_q[s] <= '0;
                    y1_q[s] <= '0;
                    y2_q[s] <= '0;
                end
            end else begin
                if (accept) begin
                    cur_q        <= in_data;
                    ovf_sticky_q <= 1'b0;
                    unf_sticky_q <= 1'b0;
                    sec_idx_q    <= '0;
                end
                if (state_q == RUN) begin
                    x2_q[sec_idx_q] <= x1_q[sec_idx_q];
                    x1_q[sec_idx_q] <= cur_q;
                    y2_q[sec_idx_q] <= y1_q[sec_idx_q];
                    y1_q[sec_idx_q] <= rounded;
                    cur_q           <= rounded;
                    ovf_sticky_q    <= ovf_sticky_q | sat_ovf;
                    unf_sticky_q    <= unf_sticky_q | sat_unf;
                    if (last_sec) begin
                        out_data_q  <= rounded;
                        overflow_q  <= ovf_sticky_q | sat_ovf;
                        underflow_q <= unf_sticky_q | sat_unf;
                        out_valid_q <= 1'b1;
                    end else begin
                        sec_idx_q <= sec_idx_q + SEC_W'(1);
                    end
                end
                if (state_q == BYP) begin
                    out_data_q  <= cur_q;
                    overflow_q  <= 1'b0;
                    underflow_q <= 1'b0;
                    out_valid_q <= 1'b1;
                end
            end
            if (wr_ok) begin
                unique case (coeff_sel)
                    B0:      b0_q[coeff_sec] <= coeff_data;
                    B1:      b1_q[coeff_sec] <= coeff_data;
                    B2:      b2_q[coeff_sec] <= coeff_data;
                    A1:      a1_q[coeff_sec] <= coeff_data;
                    A2:      a2_q[coeff_sec] <= coeff_data;
                    default: ;
                endcase
            end
        end
    end

    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;
    assign coeff_wr_err = coeff_wr_err_q;

endmodule

// File: tb/tb_iir_biquad_cascade.sv
// Self-checking bench: vector table driven through a scoreboard queue,
// plus hand sequences for latency, write rejection, flush and bypass.
module tb_iir_biquad_cascade;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        bypass = 1'b0;
    logic        flush = 1'b0;
    logic        coeff_wr_en = 1'b0;
    logic [1:0]  coeff_sec = '0;
    logic [2:0]  coeff_sel = '0;
    logic [19:0] coeff_data = '0;
    logic        coeff_wr_err;
    logic        out_valid;
    logic [15:0] out_data;
    logic        overflow;
    logic        underflow;

    always #5 clk = ~clk;

    iir_biquad_cascade dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .bypass       (bypass),
        .flush        (flush),
        .coeff_wr_en  (coeff_wr_en),
        .coeff_sec    (coeff_sec),
        .coeff_sel    (coeff_sel),
        .coeff_data   (coeff_data),
        .coeff_wr_err (coeff_wr_err),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    typedef struct {
        logic [15:0] din;
        logic        byp;
        int          lat;   // 0: untimed, else exact cycles from accept to out_valid
        logic [15:0] dout;
        logic        ovf;
        logic        unf;
    } vec_t;

    typedef struct {
        logic [15:0] dout;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[20];
    int   errors = 0;
    int   checks = 0;
    int   outputs_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] din, input logic byp, input int lat,
                                input logic [15:0] dout, input logic ovf, input logic unf);
        vec_t v;
        v.din = din; v.byp = byp; v.lat = lat; v.dout = dout; v.ovf = ovf; v.unf = unf;
        return v;
    endfunction

    // Output monitor: pop and compare on every out_valid
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                outputs_seen++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got out_valid with data 0x%0h, expected none",
                             out_data);
                end else begin
                    e = sb.pop_front();
                    check("out_data", 32'(out_data), 32'(e.dout));
                    check("flags", 32'({overflow, underflow}), 32'({e.ovf, e.unf}));
                end
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got in_ready=0 after 100 cycles, expected 1");
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || !in_ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0 || !in_ready) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got %0d pending outputs, expected 0", sb.size());
        end
    endtask

    task automatic send(input vec_t v);
        exp_t e;
        e.dout = v.dout; e.ovf = v.ovf; e.unf = v.unf;
        wait_ready();
        sb.push_back(e);
        in_data  = v.din;
        bypass   = v.byp;
        in_valid = 1'b1;
        if (v.lat == 0) begin
            @(negedge clk);
            in_valid = 1'b0;
            bypass   = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            bypass   = 1'b0;
            for (int c = 0; c < v.lat; c++) begin
                check("busy_ready", 32'(in_ready), 32'd0);
                check("early_valid", 32'(out_valid), 32'd0);
                @(posedge clk);
                #1;
            end
            check("latency_valid", 32'(out_valid), 32'd1);
            check("ready_on_out", 32'(in_ready), 32'd1);
        end
    endtask

    task automatic run(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) send(vecs[i]);
    endtask

    task automatic write_coeff(input logic [1:0] sec, input logic [2:0] sel,
                               input logic [19:0] data, input logic exp_err);
        @(negedge clk);
        coeff_wr_en = 1'b1;
        coeff_sec   = sec;
        coeff_sel   = sel;
        coeff_data  = data;
        @(posedge clk);
        #1;
        coeff_wr_en = 1'b0;
        check("wr_err", 32'(coeff_wr_err), 32'(exp_err));
    endtask

    task automatic do_flush();
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   n0;

        // Pass-through defaults
        vecs[0]  = mk(16'h4000, 1'b0, 3, 16'h4000, 1'b0, 1'b0);
        vecs[1]  = mk(16'h8000, 1'b0, 0, 16'h8000, 1'b0, 1'b0);
        vecs[2]  = mk(16'h7FFF, 1'b0, 0, 16'h7FFF, 1'b0, 1'b0);
        vecs[3]  = mk(16'h1234, 1'b0, 0, 16'h1234, 1'b0, 1'b0);
        // sec0 b0 = 0.5, rounding half up
        vecs[4]  = mk(16'h4000, 1'b0, 0, 16'h2000, 1'b0, 1'b0);
        vecs[5]  = mk(16'h7FFF, 1'b0, 0, 16'h4000, 1'b0, 1'b0);
        vecs[6]  = mk(16'h8000, 1'b0, 0, 16'hC000, 1'b0, 1'b0);
        vecs[7]  = mk(16'hFFFF, 1'b0, 0, 16'h0000, 1'b0, 1'b0);
        vecs[8]  = mk(16'h0003, 1'b0, 0, 16'h0002, 1'b0, 1'b0);
        // sec1 a1 = -0.5 impulse response
        vecs[9]  = mk(16'h4000, 1'b0, 0, 16'h4000, 1'b0, 1'b0);
        vecs[10] = mk(16'h0000, 1'b0, 0, 16'h2000, 1'b0, 1'b0);
        vecs[11] = mk(16'h0000, 1'b0, 0, 16'h1000, 1'b0, 1'b0);
        vecs[12] = mk(16'h0000, 1'b0, 0, 16'h0800, 1'b0, 1'b0);
        // sec0 b0 ~ 2.0 saturation
        vecs[13] = mk(16'h7FFF, 1'b0, 0, 16'h7FFF, 1'b1, 1'b0);
        vecs[14] = mk(16'h8000, 1'b0, 0, 16'h8000, 1'b0, 1'b1);
        vecs[15] = mk(16'h0100, 1'b0, 0, 16'h0200, 1'b0, 1'b0);
        // Bypass inside an a1 = -0.5 impulse response
        vecs[16] = mk(16'h4000, 1'b0, 0, 16'h4000, 1'b0, 1'b0);
        vecs[17] = mk(16'h1234, 1'b1, 1, 16'h1234, 1'b0, 1'b0);
        vecs[18] = mk(16'h0000, 1'b0, 0, 16'h2000, 1'b0, 1'b0);
        vecs[19] = mk(16'h0000, 1'b0, 0, 16'h1000, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_underflow", 32'(underflow), 32'd0);
        check("rst_wr_err", 32'(coeff_wr_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run(0, 3);

        wait_idle();
        write_coeff(2'd0, 3'd0, 20'h20000, 1'b0);
        run(4, 8);

        wait_idle();
        write_coeff(2'd0, 3'd0, 20'h40000, 1'b0);
        write_coeff(2'd1, 3'd3, 20'hE0000, 1'b0);
        do_flush();
        run(9, 12);

        wait_idle();
        write_coeff(2'd1, 3'd3, 20'h00000, 1'b0);
        do_flush();
        write_coeff(2'd0, 3'd0, 20'h7FFFF, 1'b0);
        run(13, 15);

        wait_idle();
        write_coeff(2'd0, 3'd0, 20'h40000, 1'b0);
        write_coeff(2'd1, 3'd3, 20'hE0000, 1'b0);
        do_flush();
        run(16, 19);

        wait_idle();
        write_coeff(2'd1, 3'd3, 20'h00000, 1'b0);
        do_flush();

        // Write while RUN is rejected and leaves b0 at 1.0
        send(vecs[3]);
        write_coeff(2'd0, 3'd0, 20'h20000, 1'b1);
        wait_idle();
        send(vecs[0]);

        // Write coinciding with an accept is rejected
        wait_idle();
        wait_ready();
        e.dout = 16'h4000; e.ovf = 1'b0; e.unf = 1'b0;
        sb.push_back(e);
        in_data     = 16'h4000;
        in_valid    = 1'b1;
        coeff_wr_en = 1'b1;
        coeff_sec   = 2'd0;
        coeff_sel   = 3'd0;
        coeff_data  = 20'h20000;
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        coeff_wr_en = 1'b0;
        check("wr_err_accept", 32'(coeff_wr_err), 32'd1);

        // IDLE write applies; out-of-range section or selector is rejected
        wait_idle();
        write_coeff(2'd0, 3'd0, 20'h20000, 1'b0);
        send(vecs[4]);
        wait_idle();
        write_coeff(2'd3, 3'd0, 20'h40000, 1'b1);
        write_coeff(2'd0, 3'd5, 20'h40000, 1'b1);
        send(vecs[4]);

        // Flush aborts a sample in flight and blocks a simultaneous accept
        wait_idle();
        write_coeff(2'd0, 3'd0, 20'h40000, 1'b0);
        write_coeff(2'd1, 3'd3, 20'hE0000, 1'b0);
        wait_ready();
        in_data  = 16'h4000;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b1;
        #1;
        check("flush_ready_run", 32'(in_ready), 32'd0);
        @(negedge clk);
        flush    = 1'b0;
        @(negedge clk);
        flush    = 1'b1;
        in_data  = 16'h7FFF;
        in_valid = 1'b1;
        #1;
        check("flush_ready_idle", 32'(in_ready), 32'd0);
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        n0 = outputs_seen;
        repeat (8) @(negedge clk);
        check("no_out_after_flush", 32'(outputs_seen), 32'(n0));
        check("idle_after_flush", 32'(in_ready), 32'd1);
        run(9, 12);

        wait_idle();
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
